// File: rtl/gm_rr_arb_if.sv
// Bundle of all requester-side and gen_m0 command/response signals around gm_rr_arb.
// Modports:
//   master - the arbiter's view: it takes the requests, drives the gen_m0 command
//            port and routes the gen_m0 responses back to their owners.
//   slave  - the environment's view: the requesters plus the gm bridge.
interface gm_rr_arb_if #(
  parameter int unsigned DW = 512,
  parameter int unsigned AW = 64
);
  // Read requester
  logic          r_req;
  logic [AW-1:0] r_addr;
  logic [3:0]    r_len;
  logic          r_gnt;
  logic [DW-1:0] r_dat;
  logic          r_val;
  logic          r_last;
  logic          r_err;
  // Write requester
  logic            w_req;
  logic [AW-1:0]   w_addr;
  logic [3:0]      w_len;
  logic [DW-1:0]   w_dat;
  logic [DW/8-1:0] w_strb;
  logic            w_gnt;
  logic            w_done;
  logic            w_err;
  // Generic master command port
  logic [AW-1:0]   gen_m0_maddr;
  logic [3:0]      gen_m0_mlen;
  logic [DW-1:0]   gen_m0_mdata;
  logic [DW/8-1:0] gen_m0_mwstrb;
  logic            gen_m0_mread;
  logic            gen_m0_mwrite;
  logic            gen_m0_mid;
  logic [2:0]      gen_m0_msize;
  logic [1:0]      gen_m0_mburst;
  logic [3:0]      gen_m0_mcache;
  logic [2:0]      gen_m0_mprot;
  logic            gen_m0_mlock;
  logic            gen_m0_mready;
  // Generic master response side
  logic            gen_m0_saccept;
  logic [DW-1:0]   gen_m0_sdata;
  logic            gen_m0_sid;
  logic            gen_m0_svalid;
  logic            gen_m0_slast;
  logic [2:0]      gen_m0_sresp;

  modport master (
    input  r_req, r_addr, r_len,
    output r_gnt, r_dat, r_val, r_last, r_err,
    input  w_req, w_addr, w_len, w_dat, w_strb,
    output w_gnt, w_done, w_err,
    output gen_m0_maddr, gen_m0_mlen, gen_m0_mdata, gen_m0_mwstrb, gen_m0_mread,
    output gen_m0_mwrite, gen_m0_mid, gen_m0_msize, gen_m0_mburst, gen_m0_mcache,
    output gen_m0_mprot, gen_m0_mlock, gen_m0_mready,
    input  gen_m0_saccept, gen_m0_sdata, gen_m0_sid, gen_m0_svalid, gen_m0_slast,
    input  gen_m0_sresp
  );

  modport slave (
    output r_req, r_addr, r_len,
    input  r_gnt, r_dat, r_val, r_last, r_err,
    output w_req, w_addr, w_len, w_dat, w_strb,
    input  w_gnt, w_done, w_err,
    input  gen_m0_maddr, gen_m0_mlen, gen_m0_mdata, gen_m0_mwstrb, gen_m0_mread,
    input  gen_m0_mwrite, gen_m0_mid, gen_m0_msize, gen_m0_mburst, gen_m0_mcache,
    input  gen_m0_mprot, gen_m0_mlock, gen_m0_mready,
    output gen_m0_saccept, gen_m0_sdata, gen_m0_sid, gen_m0_svalid, gen_m0_slast,
    output gen_m0_sresp
  );
endinterface

// File: rtl/gm_rr_arb.sv
// Two-requester round-robin arbiter in front of the gm-to-AXI bridge command port.
// Serves a read requester (single read commands) and a write requester (multi-beat
// bursts that are never interrupted), tags commands with mid (0 read, 1 write) and
// routes responses back by sid. Outstanding read bursts are capped at MAX_RD_OUT.
// Ports:
//   clk    - axi_clk
//   rst    - asynchronous, active-high reset
//   bus_io - gm_rr_arb_if master modport (requesters + gen_m0 command/response)
module gm_rr_arb #(
  parameter int unsigned DW         = 512,
  parameter int unsigned AW         = 64,
  parameter int unsigned MAX_RD_OUT = 4
) (
  input logic         clk,
  input logic         rst,
  gm_rr_arb_if.master bus_io
);

  localparam int unsigned CntW = $clog2(MAX_RD_OUT + 1);

  typedef enum logic [1:0] {StIdle, StRd, StWr} state_e;

  state_e        state_q;
  logic          last_wr_q;
  logic [3:0]    beat_cnt_q;
  logic [CntW-1:0] rd_out_q;
  logic [AW-1:0] addr_q;
  logic [3:0]    len_q;
  logic          mread_q;
  logic          mwrite_q;
  logic          mid_q;

  logic rd_ok, pick_rd, pick_wr;
  logic rd_inc, rd_dec, rd_resp, wr_resp;
  logic accept;

  assign accept  = bus_io.gen_m0_saccept;
  assign rd_ok   = bus_io.r_req && (rd_out_q < CntW'(MAX_RD_OUT));
  // On contention the requester not served last wins.
  assign pick_rd = rd_ok && (!bus_io.w_req || last_wr_q);
  assign pick_wr = bus_io.w_req && !pick_rd;

  assign rd_resp = bus_io.gen_m0_svalid && !bus_io.gen_m0_sid;
  assign wr_resp = bus_io.gen_m0_svalid && bus_io.gen_m0_sid && bus_io.gen_m0_slast;
  assign rd_inc  = (state_q == StRd) && accept;
  // Responses that arrive after a reset are untracked; never underflow.
  assign rd_dec  = rd_resp && bus_io.gen_m0_slast && (rd_out_q != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      last_wr_q  <= 1'b0;
      beat_cnt_q <= '0;
      rd_out_q   <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      mread_q    <= 1'b0;
      mwrite_q   <= 1'b0;
      mid_q      <= 1'b0;
    end else begin
      if (rd_inc && !rd_dec) begin
        rd_out_q <= rd_out_q + CntW'(1);
      end else if (rd_dec && !rd_inc) begin
        rd_out_q <= rd_out_q - CntW'(1);
      end

      unique case (state_q)
        StIdle: begin
          beat_cnt_q <= '0;
          if (pick_rd) begin
            state_q <= StRd;
            addr_q  <= bus_io.r_addr;
            len_q   <= bus_io.r_len;
            mread_q <= 1'b1;
            mid_q   <= 1'b0;
          end else if (pick_wr) begin
            state_q  <= StWr;
            addr_q   <= bus_io.w_addr;
            len_q    <= bus_io.w_len;
            mwrite_q <= 1'b1;
            mid_q    <= 1'b1;
          end
        end
        StRd: begin
          if (accept) begin
            state_q   <= StIdle;
            mread_q   <= 1'b0;
            last_wr_q <= 1'b0;
          end
        end
        StWr: begin
          if (accept) begin
            beat_cnt_q <= beat_cnt_q + 4'd1;
            if (beat_cnt_q == len_q) begin
              state_q   <= StIdle;
              mwrite_q  <= 1'b0;
              mid_q     <= 1'b0;
              last_wr_q <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Grants are combinational from saccept so they land in the accepting cycle.
  assign bus_io.r_gnt = rd_inc;
  assign bus_io.w_gnt = (state_q == StWr) && accept;

  assign bus_io.gen_m0_maddr  = addr_q;
  assign bus_io.gen_m0_mlen   = len_q;
  assign bus_io.gen_m0_mread  = mread_q;
  assign bus_io.gen_m0_mwrite = mwrite_q;
  assign bus_io.gen_m0_mid    = mid_q;
  assign bus_io.gen_m0_mdata  = mwrite_q ? bus_io.w_dat : '0;
  assign bus_io.gen_m0_mwstrb = mwrite_q ? bus_io.w_strb : '0;
  assign bus_io.gen_m0_msize  = 3'($clog2(DW / 8));
  assign bus_io.gen_m0_mburst = 2'b01;
  assign bus_io.gen_m0_mcache = 4'b0011;
  assign bus_io.gen_m0_mprot  = 3'b000;
  assign bus_io.gen_m0_mlock  = 1'b0;
  assign bus_io.gen_m0_mready = 1'b1;

  assign bus_io.r_val  = rd_resp;
  assign bus_io.r_dat  = rd_resp ? bus_io.gen_m0_sdata : '0;
  assign bus_io.r_last = rd_resp && bus_io.gen_m0_slast;
  assign bus_io.r_err  = rd_resp && (bus_io.gen_m0_sresp != 3'b000);
  assign bus_io.w_done = wr_resp;
  assign bus_io.w_err  = wr_resp && (bus_io.gen_m0_sresp != 3'b000);

endmodule

// File: tb/tb_gm_rr_arb.sv
// Directed bench for gm_rr_arb: a table of single-cycle vectors from reset followed
// by hand-written multi-cycle sequences (toggled-accept write burst, contention,
// outstanding-read limit, reset in the middle of a burst).
module tb_gm_rr_arb;
  localparam int unsigned DW       = 512;
  localparam int unsigned AW       = 64;
  localparam int unsigned MaxRdOut = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gm_rr_arb_if #(.DW(DW), .AW(AW)) bus ();

  gm_rr_arb #(.DW(DW), .AW(AW), .MAX_RD_OUT(MaxRdOut)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // {r_req, w_req, saccept, svalid, sid, slast, sresp} -> expected outputs
  // exp_o = {mread, mwrite, mid, r_gnt, w_gnt, r_val, r_last, r_err, w_done, w_err}
  typedef struct packed {
    logic       r_req;
    logic       w_req;
    logic       acc;
    logic       sv;
    logic       sid;
    logic       sl;
    logic [2:0] sresp;
    logic [9:0] exp_o;
    logic [2:0] exp_rd;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic w, input logic a, input logic sv,
                              input logic sid, input logic sl, input logic [2:0] sr,
                              input logic [9:0] e, input logic [2:0] rd);
    vec_t v;
    v.r_req = r; v.w_req = w; v.acc = a; v.sv = sv; v.sid = sid; v.sl = sl;
    v.sresp = sr; v.exp_o = e; v.exp_rd = rd;
    return v;
  endfunction

  function automatic logic [9:0] outs();
    return {bus.gen_m0_mread, bus.gen_m0_mwrite, bus.gen_m0_mid, bus.r_gnt, bus.w_gnt,
            bus.r_val, bus.r_last, bus.r_err, bus.w_done, bus.w_err};
  endfunction

  task automatic clear_inputs();
    bus.r_req = 1'b0; bus.r_addr = '0; bus.r_len = '0;
    bus.w_req = 1'b0; bus.w_addr = '0; bus.w_len = '0; bus.w_dat = '0; bus.w_strb = '0;
    bus.gen_m0_saccept = 1'b0; bus.gen_m0_sdata = '0; bus.gen_m0_sid = 1'b0;
    bus.gen_m0_svalid = 1'b0; bus.gen_m0_slast = 1'b0; bus.gen_m0_sresp = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic resp(input logic sv, input logic sid, input logic sl, input logic [2:0] sr);
    bus.gen_m0_svalid = sv; bus.gen_m0_sid = sid; bus.gen_m0_slast = sl; bus.gen_m0_sresp = sr;
  endtask

  // Waits (bounded) for an r_gnt pulse; returns at #1 after the negedge of that cycle.
  task automatic wait_rgnt(input string name);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      #1;
      got = bus.r_gnt;
    end
    chk(name, got, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int gnts;
    int cyc;
    int k;
    clear_inputs();

    // ---------------- reset values ----------------
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("reset outputs", outs(), 10'b0);
    chk("reset maddr", bus.gen_m0_maddr, '0);
    chk("reset constants", {bus.gen_m0_msize, bus.gen_m0_mburst, bus.gen_m0_mcache,
                            bus.gen_m0_mprot, bus.gen_m0_mlock, bus.gen_m0_mready},
        {3'd6, 2'b01, 4'b0011, 3'b000, 1'b0, 1'b1});
    chk("reset rd_out", dut.rd_out_q, 0);
    rst = 1'b0;

    // ---------------- table-driven vectors ----------------
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 3'd0, 10'b0000000000, 3'd0);
    vecs[1]  = mk(1, 0, 1, 0, 0, 0, 3'd0, 10'b0000000000, 3'd0);  // read seen in idle
    vecs[2]  = mk(1, 0, 1, 0, 0, 0, 3'd0, 10'b1001000000, 3'd0);  // mread + r_gnt at n+1
    vecs[3]  = mk(0, 0, 1, 0, 0, 0, 3'd0, 10'b0000000000, 3'd1);
    vecs[4]  = mk(0, 0, 0, 1, 0, 0, 3'd0, 10'b0000010000, 3'd1);  // beat 1
    vecs[5]  = mk(0, 0, 0, 1, 0, 0, 3'd0, 10'b0000010000, 3'd1);
    vecs[6]  = mk(0, 0, 0, 1, 0, 0, 3'd0, 10'b0000010000, 3'd1);
    vecs[7]  = mk(0, 0, 0, 1, 0, 1, 3'd0, 10'b0000011000, 3'd1);  // beat 4, r_last
    vecs[8]  = mk(0, 0, 0, 0, 0, 0, 3'd0, 10'b0000000000, 3'd0);
    vecs[9]  = mk(0, 0, 0, 1, 0, 0, 3'd2, 10'b0000010100, 3'd0);  // read beat with error
    vecs[10] = mk(0, 0, 0, 1, 1, 0, 3'd0, 10'b0000000000, 3'd0);  // write resp, not last
    vecs[11] = mk(0, 0, 0, 1, 1, 1, 3'd0, 10'b0000000010, 3'd0);
    vecs[12] = mk(0, 0, 0, 1, 1, 1, 3'd2, 10'b0000000011, 3'd0);
    vecs[13] = mk(0, 1, 1, 0, 0, 0, 3'd0, 10'b0000000000, 3'd0);  // 2-beat write
    vecs[14] = mk(0, 1, 1, 0, 0, 0, 3'd0, 10'b0110100000, 3'd0);
    vecs[15] = mk(0, 1, 0, 0, 0, 0, 3'd0, 10'b0110000000, 3'd0);
    vecs[16] = mk(0, 1, 1, 0, 0, 0, 3'd0, 10'b0110100000, 3'd0);
    vecs[17] = mk(0, 0, 1, 0, 0, 0, 3'd0, 10'b0000000000, 3'd0);

    bus.r_addr = 64'h1000; bus.r_len = 4'd3;
    bus.w_addr = 64'h2000; bus.w_len = 4'd1;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      bus.r_req = vecs[i].r_req;
      bus.w_req = vecs[i].w_req;
      bus.gen_m0_saccept = vecs[i].acc;
      resp(vecs[i].sv, vecs[i].sid, vecs[i].sl, vecs[i].sresp);
      #1;
      chk($sformatf("vec%0d outputs", i), outs(), vecs[i].exp_o);
      chk($sformatf("vec%0d rd_out", i), dut.rd_out_q, vecs[i].exp_rd);
      if (i == 2) begin
        chk("vec2 maddr/mlen", {bus.gen_m0_maddr, bus.gen_m0_mlen}, {64'h1000, 4'd3});
      end
    end
    clear_inputs();

    // ---------------- 8-beat write, accept toggled ----------------
    @(negedge clk);
    bus.w_req = 1'b1; bus.w_addr = 64'h2000; bus.w_len = 4'd7;
    #1;
    chk("wr idle mwrite", bus.gen_m0_mwrite, 1'b0);
    gnts = 0;
    cyc  = 0;
    while (gnts < 8 && cyc < 40) begin
      @(negedge clk);
      bus.gen_m0_saccept = (cyc % 2 == 0);
      bus.w_dat  = DW'(64'hA5A5_0000 + gnts);
      bus.w_strb = {(DW/8){1'b1}};
      #1;
      chk("wr mwrite held", bus.gen_m0_mwrite, 1'b1);
      chk("wr w_gnt follows accept", bus.w_gnt, bus.gen_m0_saccept);
      if (cyc == 0) begin
        chk("wr maddr/mlen/mid", {bus.gen_m0_maddr, bus.gen_m0_mlen, bus.gen_m0_mid},
            {64'h2000, 4'd7, 1'b1});
      end
      if (bus.w_gnt) begin
        chk("wr mdata", bus.gen_m0_mdata, DW'(64'hA5A5_0000 + gnts));
        gnts++;
      end
      cyc++;
    end
    chk("wr beat count", gnts, 8);
    @(negedge clk);
    bus.w_req = 1'b0;
    bus.gen_m0_saccept = 1'b1;
    #1;
    chk("wr idle after burst", {bus.gen_m0_mwrite, bus.w_gnt}, 2'b00);
    @(negedge clk);
    bus.gen_m0_saccept = 1'b0;
    resp(1'b1, 1'b1, 1'b1, 3'd2);
    #1;
    chk("wr response", {bus.w_done, bus.w_err, bus.r_val}, 3'b110);
    clear_inputs();

    // ---------------- contention: alternation starting with write ----------------
    do_reset();
    bus.r_addr = 64'h1000; bus.r_len = 4'd3;
    bus.w_addr = 64'h2000; bus.w_len = 4'd0;
    bus.r_req = 1'b1; bus.w_req = 1'b1; bus.gen_m0_saccept = 1'b1;
    k = 0;
    for (int c = 0; c < 40 && k < 8; c++) begin
      @(negedge clk);
      #1;
      if (bus.r_gnt || bus.w_gnt) begin
        chk($sformatf("contention grant %0d", k), {bus.r_gnt, bus.w_gnt},
            (k % 2 == 0) ? 2'b01 : 2'b10);
        chk($sformatf("contention maddr %0d", k), bus.gen_m0_maddr,
            (k % 2 == 0) ? 64'h2000 : 64'h1000);
        k++;
      end
    end
    chk("contention grant count", k, 8);
    clear_inputs();

    // ---------------- outstanding read limit ----------------
    do_reset();
    bus.r_addr = 64'h4000; bus.r_len = 4'd0;
    bus.r_req = 1'b1; bus.gen_m0_saccept = 1'b1;
    k = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      if (bus.r_gnt) k++;
    end
    chk("limit read grants", k, 4);
    chk("limit rd_out full", dut.rd_out_q, 4);
    chk("limit mread stalled", bus.gen_m0_mread, 1'b0);
    // Writes still go through while reads are stalled.
    bus.w_addr = 64'h5000; bus.w_len = 4'd0; bus.w_req = 1'b1;
    k = 0;
    for (int c = 0; c < 6 && k == 0; c++) begin
      @(negedge clk);
      #1;
      if (bus.w_gnt) k++;
    end
    chk("limit write granted", k, 1);
    bus.w_req = 1'b0;
    @(negedge clk);
    resp(1'b1, 1'b0, 1'b1, 3'd0);
    #1;
    chk("limit still full on resp", {bus.r_gnt, 3'(dut.rd_out_q)}, {1'b0, 3'd4});
    @(negedge clk);
    resp(1'b0, 1'b0, 1'b0, 3'd0);
    #1;
    chk("limit slot freed", {bus.gen_m0_mread, 3'(dut.rd_out_q)}, {1'b0, 3'd3});
    @(negedge clk);
    #1;
    chk("limit 5th read granted", {bus.gen_m0_mread, bus.r_gnt}, 2'b11);
    @(negedge clk);
    resp(1'b1, 1'b0, 1'b1, 3'd0);
    #1;
    chk("limit full again", dut.rd_out_q, 4);
    @(negedge clk);
    resp(1'b0, 1'b0, 1'b0, 3'd0);
    @(negedge clk);
    resp(1'b1, 1'b0, 1'b1, 3'd0);  // accept and last beat together
    #1;
    chk("limit simultaneous cycle", {bus.r_gnt, bus.r_val}, 2'b11);
    @(negedge clk);
    resp(1'b0, 1'b0, 1'b0, 3'd0);
    bus.r_req = 1'b0;
    #1;
    chk("limit inc+dec net zero", dut.rd_out_q, 3);
    clear_inputs();

    // ---------------- reset in the middle of a write burst ----------------
    do_reset();
    bus.r_addr = 64'h6000; bus.r_len = 4'd1;
    bus.r_req = 1'b1; bus.gen_m0_saccept = 1'b1;
    wait_rgnt("rst pre-read grant");
    bus.r_req = 1'b0;
    bus.w_addr = 64'h7000; bus.w_len = 4'd7; bus.w_req = 1'b1;
    @(negedge clk);
    #1;
    chk("rst pre rd_out", dut.rd_out_q, 1);
    gnts = 0;
    for (int c = 0; c < 10 && gnts < 2; c++) begin
      @(negedge clk);
      #1;
      if (bus.w_gnt) gnts++;
    end
    chk("rst two beats done", gnts, 2);
    @(negedge clk);
    #1;
    chk("rst beat3 presented", {bus.gen_m0_mwrite, bus.w_gnt}, 2'b11);
    rst = 1'b1;
    #1;
    chk("rst immediate outputs", outs(), 10'b0);
    chk("rst rd_out cleared", dut.rd_out_q, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.w_req = 1'b0;
    bus.r_addr = 64'h3000; bus.r_len = 4'd2; bus.r_req = 1'b1;
    wait_rgnt("rst post read grant");
    chk("rst post maddr/mlen", {bus.gen_m0_maddr, bus.gen_m0_mlen}, {64'h3000, 4'd2});
    bus.r_req = 1'b0;
    @(negedge clk);
    #1;
    chk("rst post rd_out", dut.rd_out_q, 1);
    clear_inputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
